datapath: RTL and testbench
===========================

// Module: datapath
// PURPOSE
// - Register-register execution datapath for the RV32 core: 32x32 register file feeding a 32-bit ALU.
// - ALU result is written back to the register file; zero_flag is exported for branch decisions.
// - Sits between the control unit (which supplies the register numbers, ALU op and regwrite)
//   and the branch logic.
// PARAMETERS
// - DATA_WIDTH  32  register/ALU datapath width in bits
// - REG_COUNT   32  number of architectural registers (address width 5)
// PORTS
// - clock          in   1  single system clock; all state updates on its rising edge
// - reset          in   1  synchronous, active-low reset
// - read_reg_num1  in   5  register-file read address A (ALU operand A)
// - read_reg_num2  in   5  register-file read address B (ALU operand B)
// - write_reg      in   5  register-file write-back address
// - alu_control    in   4  ALU operation select
// - regwrite       in   1  write-enable for write-back
// - zero_flag      out  1  1 when the current ALU result == 0
// BEHAVIOUR
// - Clocking and reset
//   - One clock; reset is synchronous and active-low.
//   - On a rising edge with reset==0: register x[i] <= i for i = 0..31 (x0 = 0, x1 = 1, x2 = 2, ...).
//   - Reset has priority over regwrite.
// - Register file reads
//   - Combinational, asynchronous.
//   - A = x[read_reg_num1], B = x[read_reg_num2].
//   - Reading x0 always returns 0.
// - ALU
//   - Combinational; result is 32 bits, overflow/carry discarded (mod 2^32).
//   - alu_control encoding:
//     - 0000 AND
//     - 0001 OR
//     - 0010 ADD
//     - 0100 XOR
//     - 0110 SUB (A-B)
//     - 0111 SLT (signed, result 1/0)
//     - 1000 SLL (B[4:0])
//     - 1001 SRL (B[4:0])
//     - 1010 SRA (B[4:0])
//     - 1011 SLTU (unsigned)
//     - 1100 NOR
//     - all other codes: result = 0
// - zero_flag
//   - Combinational: (result == 0).
//   - Valid in the same cycle the operands and op are applied; no registering.
// - Write-back
//   - On a rising edge with reset==1 and regwrite==1: x[write_reg] <= result.
//   - Writes to x0 are ignored; x0 stays 0.
//   - Read-during-write: reads in the same cycle return the OLD value.
//     The new value is visible after the edge (no bypass).
//   - Write-back latency: 1 clock.
// - Inputs X/undriven before first use: the design places no requirement on outputs.
//   After reset, all outputs are defined.
// - Reset asserted mid-operation: any pending write that edge is discarded and all registers re-initialise.
// TESTING
// - Reset low one edge, then high. read 0,0, ADD, regwrite=0 -> result 0, zero_flag=1.
// - read 1,2, ADD -> result 3, zero_flag=0. write_reg=3, regwrite=1 for one edge -> x3 reads 3.
// - read 1,1, SUB -> zero_flag=1. read 2,1, SUB -> result 1, zero_flag=0.
// - write_reg=0, regwrite=1, read 1,2, ADD, one edge -> x0 still reads 0.
// - Op sweep, A=x5(5), B=x3(3):
//   - AND=1, OR=7, XOR=6, SLT=0, SLL=40, SRL=0, NOR=0xFFFFFFF8.
//   - Undefined code 1111 -> 0, zero_flag=1.
// - After x4 <= 20 via write-back, pull reset low one edge -> x4 reads 4. regwrite=1 during reset -> no write.

Source files
------------

// File: rtl/datapath.sv
// datapath: 32x32 register file feeding a combinational ALU with write-back
// and a zero flag for branch decisions.
module datapath #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [$clog2(REG_COUNT)-1:0] read_reg_num1,
    input  logic [$clog2(REG_COUNT)-1:0] read_reg_num2,
    input  logic [$clog2(REG_COUNT)-1:0] write_reg,
    input  logic [3:0]                   alu_control,
    input  logic                         regwrite,
    output logic                         zero_flag
);
    localparam int SW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] x [REG_COUNT];
    logic [DATA_WIDTH-1:0] a, b, result;

    // x0 is never written, so forcing reads to zero keeps it hard-wired
    assign a = (read_reg_num1 == '0) ? '0 : x[read_reg_num1];
    assign b = (read_reg_num2 == '0) ? '0 : x[read_reg_num2];

    always_comb begin
        result = '0;
        case (alu_control)
            4'b0000: result = a & b;
            4'b0001: result = a | b;
            4'b0010: result = a + b;
            4'b0100: result = a ^ b;
            4'b0110: result = a - b;
            4'b0111: result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: result = a << b[SW-1:0];
            4'b1001: result = a >> b[SW-1:0];
            4'b1010: result = $unsigned($signed(a) >>> b[SW-1:0]);
            4'b1011: result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            4'b1100: result = ~(a | b);
            default: result = '0;
        endcase
    end

    assign zero_flag = (result == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                x[i] <= DATA_WIDTH'(i);
        end else if (regwrite && write_reg != '0) begin
            x[write_reg] <= result;
        end
    end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: random and directed stimulus against an array-based model;
// register contents are observed through SUB-against-every-register probes.
module tb_datapath;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       regwrite = 1'b0;
    logic [4:0] r1 = '0, r2 = '0, wr = '0;
    logic [3:0] op = '0;
    logic       zero_flag;

    logic [31:0] m [32];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    datapath dut (
        .clock(clock),
        .reset(reset),
        .read_reg_num1(r1),
        .read_reg_num2(r2),
        .write_reg(wr),
        .alu_control(op),
        .regwrite(regwrite),
        .zero_flag(zero_flag)
    );

    function automatic logic [31:0] ref_alu(logic [3:0] o, logic [31:0] va, logic [31:0] vb);
        int sa = int'(va);
        int sb = int'(vb);
        int unsigned sh = vb % 32;
        case (o)
            4'd0:  return va & vb;
            4'd1:  return va | vb;
            4'd2:  return va + vb;
            4'd4:  return va ^ vb;
            4'd6:  return va - vb;
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return va << sh;
            4'd9:  return va >> sh;
            4'd10: return 32'(sa >>> sh);
            4'd11: return (va < vb) ? 32'd1 : 32'd0;
            4'd12: return ~(va | vb);
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                        input logic [3:0] o, input logic we, input string tag);
        logic [31:0] res;
        r1 = a; r2 = b; wr = d; op = o; regwrite = we;
        res = ref_alu(o, m[a], m[b]);
        @(negedge clock);
        check(tag, {31'b0, zero_flag}, {31'b0, res == 32'd0});
        @(posedge clock);
        if (we && d != 0) m[d] = res;
        #1 regwrite = 1'b0;
    endtask

    task automatic probe(input logic [4:0] d, input string tag);
        for (int k = 0; k < 32; k++) step(d, 5'(k), 5'd0, 4'd6, 1'b0, tag);
    endtask

    task automatic do_reset(input logic we, input logic [4:0] d);
        reset = 1'b0; regwrite = we; wr = d; op = 4'd2;
        r1 = 5'($urandom); r2 = 5'($urandom);
        @(posedge clock);
        for (int i = 0; i < 32; i++) m[i] = 32'(i);
        #1 reset = 1'b1; regwrite = 1'b0;
    endtask

    initial begin
        logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9,
                                 4'd10, 4'd11, 4'd12, 4'd15};
        @(posedge clock); #1;
        do_reset(1'b0, 5'd0);
        step(0, 0, 0, 4'd2, 0, "add_x0_x0");
        step(1, 2, 0, 4'd2, 0, "add_x1_x2");
        step(1, 2, 3, 4'd2, 1, "wb_x3");
        probe(3, "probe_x3");
        step(1, 1, 0, 4'd6, 0, "sub_equal");
        step(2, 1, 0, 4'd6, 0, "sub_2_1");
        step(1, 2, 0, 4'd2, 1, "write_x0");
        probe(0, "probe_x0");
        foreach (ops[i]) begin
            step(5, 3, 20, ops[i], 1, "op_sweep");
            probe(20, "probe_op_result");
        end
        step(16, 4, 4, 4'd2, 1, "wb_x4_20");
        probe(4, "probe_x4_20");
        do_reset(1'b1, 5'd4);
        probe(4, "probe_x4_after_reset");
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1'b1, 5'($urandom));
            step(5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom),
                 1'($urandom), "random");
            if (n % 150 == 149) probe(5'($urandom), "probe_random");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
